// File: rtl/best_d_pkg.sv
// best_d_pkg: shared defaults, FSM states and the t -> theta mapping for best_d_param
package best_d_pkg;
  localparam int N_W_DEF = 19;
  localparam int T_W_DEF = 4;
  localparam int TH_W_DEF = 4;
  localparam int FRAC_DEF = 4;
  localparam int U_MIN_DEF = 2;
  localparam int U_MAX_DEF = 17;
  typedef enum logic [1:0] {IDLE, MUL, ENC, DONE} state_e;
  function automatic int unsigned theta_of(input int unsigned t);
    return t >= 6 ? 1 : t >= 4 ? 2 : t == 3 ? 3 : t == 2 ? 4 : 8;
  endfunction
endpackage

// File: rtl/ceil_log2_clamp.sv
// ceil_log2_clamp: smallest u with 2^u >= x, clamped to [U_MIN, U_MAX]
module ceil_log2_clamp #(
  parameter int IN_W = 23,
  parameter int U_MIN = 2,
  parameter int U_MAX = 17,
  parameter int U_W = $clog2(U_MAX + 1)
) (
  input  logic [IN_W-1:0] x_i,
  output logic [U_W-1:0]  u_o
);
  logic [IN_W-1:0] xm;
  int r;
  assign xm = x_i - 1'b1;
  // one above the top set bit of x-1 is ceil(log2 x); x of 0 or 1 leaves r at 0
  always_comb begin
    r = 0;
    for (int i = 0; i < IN_W; i++) r = (|x_i && xm[i]) ? i + 1 : r;
    r = r < U_MIN ? U_MIN : r > U_MAX ? U_MAX : r;
    u_o = U_W'(r);
  end
endmodule

// File: rtl/best_d_param.sv
// best_d_param: picks d = 2^u covering n*theta(t)/2^FRAC with a bit-serial multiplier
module best_d_param
  import best_d_pkg::*;
#(
  parameter int N_W = N_W_DEF,
  parameter int T_W = T_W_DEF,
  parameter int TH_W = TH_W_DEF,
  parameter int FRAC = FRAC_DEF,
  parameter int U_MIN = U_MIN_DEF,
  parameter int U_MAX = U_MAX_DEF,
  localparam int D_W = U_MAX + 1,
  localparam int U_W = $clog2(U_MAX + 1)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N_W-1:0] n,
  input  logic [T_W-1:0] t,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [D_W-1:0] d,
  output logic [U_W-1:0] u
);
  localparam int P_W = N_W + TH_W;
  localparam int C_W = $clog2(TH_W + 1);
  state_e state_q;
  logic [P_W-1:0] mcand_q, acc_q, x;
  logic [TH_W-1:0] th_q;
  logic [C_W-1:0] cnt_q;
  logic [D_W-1:0] d_q;
  logic [U_W-1:0] u_q, enc_u;
  assign x = acc_q >> FRAC;
  assign in_ready = state_q == IDLE;
  assign out_valid = state_q == DONE;
  assign d = d_q;
  assign u = u_q;
  ceil_log2_clamp #(.IN_W(P_W), .U_MIN(U_MIN), .U_MAX(U_MAX), .U_W(U_W)) u_enc (
    .x_i(x),
    .u_o(enc_u)
  );
  // control FSM: accept, shift-add one theta bit per cycle LSB first, encode, hold until taken
  always_ff @(posedge clk)
    if (rst) begin
      state_q <= IDLE;
      mcand_q <= '0;
      acc_q <= '0;
      th_q <= '0;
      cnt_q <= '0;
      d_q <= '0;
      u_q <= '0;
    end else
      case (state_q)
        IDLE: if (in_valid) begin
          mcand_q <= P_W'(n);
          th_q <= TH_W'(theta_of(32'(t)));
          acc_q <= '0;
          cnt_q <= '0;
          state_q <= MUL;
        end
        MUL: begin
          if (th_q[0]) acc_q <= acc_q + mcand_q;
          mcand_q <= mcand_q << 1;
          th_q <= th_q >> 1;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == C_W'(TH_W - 1)) state_q <= ENC;
        end
        ENC: begin
          d_q <= D_W'(1) << enc_u;
          u_q <= enc_u;
          state_q <= DONE;
        end
        DONE: if (out_ready) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
endmodule

// File: tb/tb_best_d_param.sv
// tb_best_d_param: scoreboard-driven checks of best_d_param against a behavioural model
module tb_best_d_param;
  localparam int N_W = 19, T_W = 4, D_W = 18, U_W = 5;
  logic clk = 0, rst = 1, in_valid = 0, out_ready = 0;
  logic in_ready, out_valid;
  logic [N_W-1:0] n = '0;
  logic [T_W-1:0] t = '0;
  logic [D_W-1:0] d;
  logic [U_W-1:0] u;
  int errors = 0, checks = 0;
  typedef struct packed {logic [D_W-1:0] d; logic [U_W-1:0] u;} res_t;
  res_t exp_q[$];
  always #5 clk = ~clk;
  best_d_param dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .n(n), .t(t),
    .out_valid(out_valid), .out_ready(out_ready), .d(d), .u(u)
  );
  function automatic res_t model(input longint unsigned nn, input int unsigned tt);
    longint unsigned th, x;
    int e;
    res_t r;
    th = tt >= 6 ? 1 : tt >= 4 ? 2 : tt == 3 ? 3 : tt == 2 ? 4 : 8;
    x = (nn * th) >> 4;
    e = 0;
    while ((64'd1 << e) < x) e++;
    if (e < 2) e = 2;
    if (e > 17) e = 17;
    r.u = U_W'(e);
    r.d = D_W'(64'd1 << e);
    return r;
  endfunction
  task automatic test_reset();
    rst = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    checks++; if (d !== '0) begin errors++; $display("FAIL reset_d got=%0d want=0", d); end
    checks++; if (u !== '0) begin errors++; $display("FAIL reset_u got=%0d want=0", u); end
    @(posedge clk); #1 rst = 0;
  endtask
  task automatic test_directed();
    int vn[5] = '{1000, 524287, 64, 80, 0};
    int vt[5] = '{2, 0, 8, 3, 5};
    int vu[5] = '{8, 17, 2, 4, 2};
    int vd[5] = '{256, 131072, 4, 16, 4};
    int lat;
    res_t r;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1 n = N_W'(vn[i]); t = T_W'(vt[i]); in_valid = 1; out_ready = 1;
      r.d = D_W'(vd[i]); r.u = U_W'(vu[i]);
      exp_q.push_back(r);
      @(negedge clk);
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL dir%0d_in_ready got=%b want=1", i, in_ready); end
      @(posedge clk); #1 in_valid = 0;
      lat = 0;
      for (int k = 1; k <= 20 && lat == 0; k++) begin
        @(negedge clk);
        if (out_valid === 1'b1) lat = k;
      end
      checks++; if (lat != 6) begin errors++; $display("FAIL dir%0d_latency got=%0d want=6", i, lat); end
      if (lat != 0) begin
        r = exp_q.pop_front();
        checks++; if (d !== r.d || u !== r.u) begin errors++; $display("FAIL dir%0d_result got d=%0d u=%0d want d=%0d u=%0d", i, d, u, r.d, r.u); end
      end else exp_q.delete();
    end
  endtask
  task automatic test_stall();
    int lat;
    res_t r;
    @(posedge clk); #1 n = 1000; t = 2; in_valid = 1; out_ready = 0;
    exp_q.push_back(model(1000, 2));
    @(posedge clk); #1 in_valid = 0;
    lat = 0;
    for (int k = 1; k <= 20 && lat == 0; k++) begin
      @(negedge clk);
      if (out_valid === 1'b1) lat = k;
    end
    checks++; if (lat != 6) begin errors++; $display("FAIL stall_latency got=%0d want=6", lat); end
    r = exp_q.pop_front();
    @(posedge clk); #1 in_valid = 1; n = 5; t = 1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      checks++;
      if ({out_valid, in_ready, d, u} !== {1'b1, 1'b0, r.d, r.u}) begin
        errors++;
        $display("FAIL stall_hold%0d got v=%b rdy=%b d=%0d u=%0d want v=1 rdy=0 d=%0d u=%0d", k, out_valid, in_ready, d, u, r.d, r.u);
      end
      if (k < 9) @(posedge clk);
    end
    out_ready = 1;
    exp_q.push_back(model(5, 1));
    @(posedge clk);
    @(negedge clk);
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL stall_release got rdy=%b v=%b want rdy=1 v=0", in_ready, out_valid); end
    @(posedge clk); #1 in_valid = 0;
    lat = 0;
    for (int k = 1; k <= 20 && lat == 0; k++) begin
      @(negedge clk);
      if (out_valid === 1'b1) lat = k;
    end
    checks++; if (lat != 6) begin errors++; $display("FAIL stall_second_latency got=%0d want=6", lat); end
    if (lat != 0) begin
      r = exp_q.pop_front();
      checks++; if (d !== r.d || u !== r.u) begin errors++; $display("FAIL stall_second got d=%0d u=%0d want d=%0d u=%0d", d, u, r.d, r.u); end
    end else exp_q.delete();
  endtask
  task automatic test_reset_mid();
    int lat, seen;
    res_t r;
    @(posedge clk); #1 n = 1000; t = 2; in_valid = 1; out_ready = 1;
    exp_q.push_back(model(1000, 2));
    @(posedge clk); #1 in_valid = 0;
    @(posedge clk); #1 rst = 1;
    exp_q.delete();
    @(posedge clk); #1 rst = 0;
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (out_valid !== 1'b0) seen++;
    end
    checks++; if (seen != 0) begin errors++; $display("FAIL abort_out_valid got=%0d cycles want=0", seen); end
    @(posedge clk); #1 n = 80; t = 3; in_valid = 1;
    exp_q.push_back(model(80, 3));
    @(posedge clk); #1 in_valid = 0;
    lat = 0;
    for (int k = 1; k <= 20 && lat == 0; k++) begin
      @(negedge clk);
      if (out_valid === 1'b1) lat = k;
    end
    checks++; if (lat != 6) begin errors++; $display("FAIL abort_after_latency got=%0d want=6", lat); end
    if (lat != 0) begin
      r = exp_q.pop_front();
      checks++; if (d !== r.d || u !== r.u) begin errors++; $display("FAIL abort_after got d=%0d u=%0d want d=%0d u=%0d", d, u, r.d, r.u); end
    end else exp_q.delete();
  endtask
  task automatic test_back_to_back();
    int got, acc, last, cyc;
    bit accepted;
    res_t r;
    got = 0; acc = 0; last = -1; cyc = 0;
    @(posedge clk); #1 n = N_W'($urandom_range(0, (1 << N_W) - 1)); t = T_W'($urandom_range(0, 15)); in_valid = 1; out_ready = 1;
    while (got < 1000 && cyc < 8000) begin
      @(negedge clk);
      cyc++;
      if (out_valid === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL b2b_unexpected got d=%0d u=%0d want no result", d, u);
        end else begin
          r = exp_q.pop_front();
          if (d !== r.d || u !== r.u) begin errors++; $display("FAIL b2b_result%0d got d=%0d u=%0d want d=%0d u=%0d", got, d, u, r.d, r.u); end
        end
        got++;
      end
      accepted = in_valid && in_ready === 1'b1;
      if (accepted) begin
        exp_q.push_back(model(n, t));
        if (last >= 0) begin
          checks++; if (cyc - last != 7) begin errors++; $display("FAIL b2b_spacing got=%0d want=7", cyc - last); end
        end
        last = cyc;
        acc++;
      end
      @(posedge clk); #1;
      if (accepted) begin
        if (acc == 1000) in_valid = 0;
        else begin n = N_W'($urandom_range(0, (1 << N_W) - 1)); t = T_W'($urandom_range(0, 15)); end
      end
    end
    checks++; if (got != 1000) begin errors++; $display("FAIL b2b_count got=%0d want=1000", got); end
  endtask
  initial begin
    test_reset();
    test_directed();
    test_stall();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/best_d_param.md
BEST_D_PARAM -- requirements
Module: best_d_param

Interface
REQ-001 The block SHALL take parameter N_W, default 19, the width of input n.
REQ-002 The block SHALL take parameter T_W, default 4, the width of input t.
REQ-003 The block SHALL take parameter TH_W, default 4, the width of the theta multiplier.
REQ-004 The block SHALL take parameter FRAC, default 4, the right shift applied to the product (theta is fixed-point, divided by 2^FRAC).
REQ-005 The block SHALL take parameter U_MIN, default 2, the minimum exponent.
REQ-006 The block SHALL take parameter U_MAX, default 17, the maximum exponent; D_W = U_MAX+1 and U_W = clog2(U_MAX+1).
REQ-007 The block SHALL have ports as listed below:
  clk        in   1      the single clock; all logic is rising-edge.
  rst        in   1      synchronous, active-high reset.
  in_valid   in   1      request present.
  in_ready   out  1      the block can accept a request.
  n          in   N_W    code length operand.
  t          in   T_W    weight parameter.
  out_valid  out  1      result present.
  out_ready  in   1      consumer accepts the result.
  d          out  D_W    chosen power of two, d = 2^u.
  u          out  U_W    exponent.

Function
REQ-008 The theta mapping SHALL be: t>=6 -> 1; t=4 or t=5 -> 2; t=3 -> 3; t=2 -> 4; t<=1 -> 8.
REQ-009 The product p SHALL equal n*theta, is (N_W+TH_W) bits wide, and SHALL be exact with no truncation.
REQ-010 The scaled value SHALL be x = p >> FRAC.
REQ-011 u SHALL be the smallest integer with 2^u >= x, clamped to [U_MIN, U_MAX]; x=0 SHALL yield U_MIN.
REQ-012 d SHALL equal 1<<u, zero-extended to D_W bits.
REQ-013 The FSM SHALL have states IDLE, MUL, ENC and DONE.
REQ-014 In IDLE, in_ready=1; when in_valid=1, the block SHALL register n and theta(t), clear the accumulator and go to MUL.
REQ-015 MUL SHALL be a shift-add multiplier that processes one theta bit per cycle (LSB first) for exactly TH_W cycles, then go to ENC.
REQ-016 ENC SHALL compute u and d from the accumulator in one cycle, register them and go to DONE.
REQ-017 In DONE, out_valid=1 and d and u SHALL be held stable until out_ready=1; the transfer then completes and the FSM returns to IDLE.
REQ-018 Latency from input handshake to out_valid SHALL be TH_W+2 cycles (6 with defaults); maximum throughput is one result per TH_W+3 cycles.
REQ-019 in_ready SHALL be 0 in MUL, ENC and DONE; in_valid in those states SHALL be ignored and SHALL NOT corrupt the operation in progress.
REQ-020 out_valid SHALL be 0 in every state other than DONE.
REQ-021 The block SHALL NOT combinationally bypass DONE to IDLE and accept a new request in the same cycle; a new request is accepted earliest in the cycle after the output handshake.
REQ-022 An in_valid that is held asserted in DONE SHALL be accepted in the IDLE cycle that follows.

Reset
REQ-023 rst=1 SHALL force state=IDLE, d=0, u=0, the accumulator to 0 and out_valid=0 at the next rising edge; in_ready SHALL be 1 from the first cycle after reset.
REQ-024 Reset asserted in the middle of MUL, ENC or DONE SHALL abort the operation; no out_valid pulse SHALL follow, and a pending result SHALL be discarded.
REQ-025 rst SHALL take priority over every handshake in the same cycle.

Structure
REQ-026 Package best_d_pkg SHALL hold the theta-mapping function, the default parameter constants, and the state enumeration type.
REQ-027 The exponent encoding of REQ-011 SHALL be a single combinational sub-module, ceil_log2_clamp (parameters: input width, U_MIN, U_MAX), instantiated once in ENC.
REQ-028 The multiplier SHALL be built inline; no vendor IP core SHALL be used.

Verification
REQ-029 With n=1000, t=2 (theta 4): p=4000, x=250 -> u=8, d=256, out_valid in the 6th cycle after the handshake.
REQ-030 With n=524287, t=0 (theta 8): x=262143 -> u clamps to 17, d=131072.
REQ-031 Boundary cases SHALL give: n=64, t=8 -> x=4 -> u=2, d=4; n=80, t=3 -> x=15 -> u=4, d=16; n=0 -> u=2, d=4.
REQ-032 With out_ready held low for 10 cycles in DONE, d and u SHALL remain stable, in_ready=0, and a second in_valid SHALL be ignored until the transfer completes.
REQ-033 With rst pulsed during the 2nd MUL cycle, out_valid SHALL never assert, and a subsequent request SHALL produce a correct result.
REQ-034 Back-to-back requests with in_valid and out_ready held high SHALL be accepted one every 7 cycles, with results in order and matching a reference model over 1000 random (n, t) pairs.
